hazard_sched: RTL and testbench

Pipeline sequencing controller for the five-stage RV32I core. It tracks destination registers of in-flight instructions in EX/MEM/WB with a 3-entry scoreboard. It stalls the decode stage on read-after-write hazards, because ID reads the register file and resolves branches with no forwarding. It also freezes the whole pipeline while a data-memory access is outstanding, and flushes the fetch/decode register on taken branches. All PC, IF/ID, ID/EX and downstream pipeline-register enables come from this block.

---
 rtl/hazard_sched_if.sv | 55 +++++
 rtl/hazard_sched.sv | 168 ++++++++++++++++
 tb/tb_hazard_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sched_if.sv
// Decode-side hazard/control bundle between the ID stage and hazard_sched.
// The master drives instruction info and mem_ack; the slave returns enables.
interface hazard_sched_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_regwrite;
  logic [4:0] id_rd;
  logic       id_mem;
  logic       id_branch_taken;
  logic       mem_ack;
  logic       pc_en;
  logic       fs_ds_en;
  logic       fs_ds_flush;
  logic       ds_es_bubble;
  logic       pipe_en;

  modport master (
    output id_valid,
    output id_rs1,
    output id_rs2,
    output id_use_rs1,
    output id_use_rs2,
    output id_regwrite,
    output id_rd,
    output id_mem,
    output id_branch_taken,
    output mem_ack,
    input  pc_en,
    input  fs_ds_en,
    input  fs_ds_flush,
    input  ds_es_bubble,
    input  pipe_en
  );

  modport slave (
    input  id_valid,
    input  id_rs1,
    input  id_rs2,
    input  id_use_rs1,
    input  id_use_rs2,
    input  id_regwrite,
    input  id_rd,
    input  id_mem,
    input  id_branch_taken,
    input  mem_ack,
    output pc_en,
    output fs_ds_en,
    output fs_ds_flush,
    output ds_es_bubble,
    output pipe_en
  );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline sequencing controller: RAW stall, memory freeze, branch flush.
// Tracks EX/MEM/WB destinations in a 3-entry scoreboard.
module hazard_sched #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         resetn,
  hazard_sched_if.slave hs,
  output logic [1:0]   ctrl_state,
  output logic         mem_err,
  output logic [31:0]  stall_cycles,
  output logic [15:0]  flush_cnt
);

  localparam int WW =
    (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic       mem;
  } sb_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    RAW  = 2'd1,
    MEMW = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  sb_t           sb_ex;
  sb_t           sb_mem;
  sb_t           sb_wb;
  sb_t           sb_in;
  logic [WW-1:0] wait_cnt;

  logic hit1;
  logic hit2;
  logic hazard;
  logic hz_only;
  logic mem_pend;
  logic at_limit;
  logic memwait;
  logic freeze;
  logic timeout;
  logic flush;

  function automatic logic hits(
    input sb_t        e,
    input logic [4:0] r
  );
    return e.v & e.we & (e.rd == r) & (r != 5'd0);
  endfunction

  // WB counts: the regfile write lands after the ID read.
  always_comb begin
    hit1 = hits(sb_ex, hs.id_rs1)
         | hits(sb_mem, hs.id_rs1)
         | hits(sb_wb, hs.id_rs1);
    hit2 = hits(sb_ex, hs.id_rs2)
         | hits(sb_mem, hs.id_rs2)
         | hits(sb_wb, hs.id_rs2);
    hazard = hs.id_valid
           & ((hs.id_use_rs1 & hit1)
           |  (hs.id_use_rs2 & hit2));
  end

  always_comb begin
    mem_pend = sb_mem.v & sb_mem.mem & ~hs.mem_ack;
    at_limit = (wait_cnt == TO);
    memwait  = mem_pend & ~at_limit;
    timeout  = mem_pend & at_limit;
    freeze   = memwait;
    hz_only  = hazard & ~freeze;
  end

  // Flush is held low while in reset.
  always_comb begin
    flush = resetn & ~freeze & ~hazard
          & hs.id_valid & hs.id_branch_taken;
  end

  assign hs.pipe_en      = ~freeze;
  assign hs.pc_en        = ~freeze & ~hazard;
  assign hs.fs_ds_en     = ~freeze & ~hazard;
  assign hs.ds_es_bubble = ~freeze
                         & (hazard | ~hs.id_valid);
  assign hs.fs_ds_flush  = flush;

  always_comb begin
    sb_in = '0;
    if (hs.id_valid & ~hazard) begin
      sb_in.v   = 1'b1;
      sb_in.we  = hs.id_regwrite;
      sb_in.rd  = hs.id_rd;
      sb_in.mem = hs.id_mem;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!freeze) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= sb_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (memwait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_err <= 1'b0;
    end else if (timeout) begin
      mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    unique case (1'b1)
      freeze:  state_d = MEMW;
      hz_only: state_d = RAW;
      default: state_d = RUN;
    endcase
  end

  assign ctrl_state = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (freeze | hazard) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_cnt <= '0;
    end else if (flush && flush_cnt != 16'hFFFF) begin
      flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: queue-based pipeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hazard_sched;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  ctrl_state;
  logic        mem_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_cnt;

  hazard_sched_if hs ();

  hazard_sched #(.MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .hs           (hs.slave),
    .ctrl_state   (ctrl_state),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit       v;
    bit       we;
    bit [4:0] rd;
    bit       mem;
  } ins_t;

  // index 0 = EX, 1 = MEM, 2 = WB
  ins_t        pq[$];
  int          m_wait;
  bit          m_err;
  int unsigned m_stall;
  int          m_flush;
  int          m_state;

  function automatic bit inflight(bit [4:0] r);
    if (r == 0) return 0;
    foreach (pq[i])
      if (pq[i].v && pq[i].we && pq[i].rd == r) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    bit   hz, fz, to, fl, ld;
    ins_t n;
    ins_t e;
    e = '{v: 0, we: 0, rd: 0, mem: 0};
    if (!resetn) begin
      pq = {e, e, e};
      m_wait = 0; m_err = 0; m_stall = 0;
      m_flush = 0; m_state = 0;
    end
    hz = hs.id_valid
      && ((hs.id_use_rs1 && inflight(hs.id_rs1))
      ||  (hs.id_use_rs2 && inflight(hs.id_rs2)));
    ld = pq[1].v && pq[1].mem && !hs.mem_ack;
    fz = ld && (m_wait < TO);
    to = ld && (m_wait == TO);
    fl = resetn && !fz && !hz
      && hs.id_valid && hs.id_branch_taken;
    chk("pc_en", 32'(hs.pc_en), 32'(!fz && !hz));
    chk("fs_ds_en", 32'(hs.fs_ds_en), 32'(!fz && !hz));
    chk("pipe_en", 32'(hs.pipe_en), 32'(!fz));
    chk("bubble", 32'(hs.ds_es_bubble),
        32'(!fz && (hz || !hs.id_valid)));
    chk("flush", 32'(hs.fs_ds_flush), 32'(fl));
    chk("state", 32'(ctrl_state), 32'(m_state));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    chk("stall_cnt", stall_cycles, m_stall);
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (resetn) begin
      if (!fz) begin
        n = e;
        if (hs.id_valid && !hz)
          n = '{v: 1, we: hs.id_regwrite,
                rd: hs.id_rd, mem: hs.id_mem};
        pq.push_front(n);
        void'(pq.pop_back());
        m_wait = 0;
      end else begin
        m_wait++;
      end
      if (to) m_err = 1;
      if (fz || hz) m_stall++;
      if (fl && m_flush < 65535) m_flush++;
      m_state = fz ? 2 : (hz ? 1 : 0);
    end
  end

  bit       s_pc, s_pipe, s_fl, s_bub;
  bit [1:0] s_st;

  task automatic drv(bit v, bit [4:0] r1, bit [4:0] r2,
                     bit u1, bit u2, bit we, bit [4:0] rd,
                     bit mem, bit br, bit ack);
    hs.id_valid = v;
    hs.id_rs1 = r1;
    hs.id_rs2 = r2;
    hs.id_use_rs1 = u1;
    hs.id_use_rs2 = u2;
    hs.id_regwrite = we;
    hs.id_rd = rd;
    hs.id_mem = mem;
    hs.id_branch_taken = br;
    hs.mem_ack = ack;
    @(negedge clk);
    s_pc = hs.pc_en;
    s_pipe = hs.pipe_en;
    s_fl = hs.fs_ds_flush;
    s_bub = hs.ds_es_bubble;
    s_st = ctrl_state;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit ack);
    repeat (n) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, ack);
  endtask

  initial begin
    int       cnt, bcnt;
    bit [3:0] pat;
    bit [3:0] stp;
    resetn = 1'b0;
    hs.id_valid = 1; hs.id_rs1 = 0; hs.id_rs2 = 0;
    hs.id_use_rs1 = 0; hs.id_use_rs2 = 0;
    hs.id_regwrite = 0; hs.id_rd = 0; hs.id_mem = 0;
    hs.id_branch_taken = 1; hs.mem_ack = 1;
    @(negedge clk);
    chk("rst_pc_en", 32'(hs.pc_en), 1);
    chk("rst_pipe_en", 32'(hs.pipe_en), 1);
    chk("rst_flush", 32'(hs.fs_ds_flush), 0);
    chk("rst_bubble", 32'(hs.ds_es_bubble), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1, 1);

    // RAW on an EX producer: 3 stalls
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 1);
    cnt = 0; bcnt = 0; stp = 0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 5, 1, 1, 1, 1, 6, 0, 0, 1);
      if (!s_pc) cnt++;
      if (s_bub) bcnt++;
      stp[i] = (s_st == 2'd1);
    end
    chk("raw_pc_stalls", 32'(cnt), 3);
    chk("raw_bubbles", 32'(bcnt), 3);
    chk("raw_state_seq", 32'(stp), 32'h0E);
    idle(1, 1);
    chk("raw_state_back", 32'(s_st), 0);
    idle(2, 1);
    chk("raw_stall_cnt", stall_cycles, 3);

    // x0 producer never hazards
    drv(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    drv(1, 0, 0, 1, 0, 1, 9, 0, 0, 1);
    chk("x0_no_stall", 32'(s_pc), 1);
    idle(3, 1);

    // plain taken branch
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("br_flush", 32'(s_fl), 1);
    idle(1, 1);
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    // branch on a just-produced reg: flush after 3 stalls
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 1);
    pat = 0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 7, 0, 1, 1, 0, 0, 0, 1, 1);
      pat[i] = s_fl;
    end
    chk("br_dep_flush_pat", 32'(pat), 32'h8);
    idle(3, 1);
    chk("br_dep_flush_cnt", 32'(flush_cnt), 2);
    chk("br_dep_stall_cnt", stall_cycles, 6);

    // load frozen 4 cycles before ack
    drv(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1, 0);
      if (!s_pipe) cnt++;
      if (i == 2) chk("memw_state", 32'(s_st), 2);
    end
    idle(1, 1);
    chk("memw_ack_release", 32'(s_pipe), 1);
    chk("memw_freeze_cycles", 32'(cnt), 4);
    idle(3, 1);
    chk("memw_stall_cnt", stall_cycles, 10);
    chk("memw_no_err", 32'(mem_err), 0);

    // no ack ever: timeout after TO cycles
    drv(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      idle(1, 0);
      if (!s_pipe) cnt++;
    end
    chk("to_freeze_cycles", 32'(cnt), 4);
    chk("to_mem_err", 32'(mem_err), 1);
    chk("to_stall_cnt", stall_cycles, 14);
    idle(3, 1);
    chk("to_err_sticky", 32'(mem_err), 1);

    // reset in the middle of a freeze
    drv(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    idle(3, 0);
    chk("pre_rst_frozen", 32'(hs.pipe_en), 0);
    resetn = 1'b0;
    #1;
    chk("mrst_pipe_en", 32'(hs.pipe_en), 1);
    chk("mrst_pc_en", 32'(hs.pc_en), 1);
    chk("mrst_mem_err", 32'(mem_err), 0);
    chk("mrst_stall", stall_cycles, 0);
    chk("mrst_flush", 32'(flush_cnt), 0);
    chk("mrst_state", 32'(ctrl_state), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    drv(1, 8, 8, 1, 1, 1, 3, 0, 0, 1);
    chk("post_rst_no_hz", 32'(s_pc), 1);
    idle(2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
